// File: rtl/keypad_emulator.sv
// Stands in for the 4x3 key matrix: answers the scanner's row strobes with column
// levels as if one key were held, sequencing each accepted code through PRESS then GAP.
module keypad_emulator #(
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_row,
   output logic [2:0] key_col,
   input  logic       cmd_valid,
   input  logic [3:0] cmd_code,
   output logic       cmd_ready,
   output logic       busy,
   output logic [3:0] held_code,
   output logic       done,
   output logic       err,
   input  logic       cancel
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [3:0]       NO_KEY    = 4'hF;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_held;
   logic             r_done;
   logic             r_err;

   logic [3:0]       w_row;
   logic [2:0]       w_col;

   function automatic logic code_valid(input logic [3:0] c);
      return (c <= 4'd9) || (c == 4'hC) || (c == 4'hD);
   endfunction

   function automatic logic [3:0] code_row(input logic [3:0] c);
      case (c)
         4'h1, 4'h2, 4'h3: return 4'b1000;
         4'h4, 4'h5, 4'h6: return 4'b0100;
         4'h7, 4'h8, 4'h9: return 4'b0010;
         4'hC, 4'h0, 4'hD: return 4'b0001;
         default:          return 4'b0000;
      endcase
   endfunction

   function automatic logic [2:0] code_col(input logic [3:0] c);
      case (c)
         4'h1, 4'h4, 4'h7, 4'hC: return 3'b100;
         4'h2, 4'h5, 4'h8, 4'h0: return 3'b010;
         4'h3, 4'h6, 4'h9, 4'hD: return 3'b001;
         default:                return 3'b000;
      endcase
   endfunction

   // Column answer is combinational so the scanner sees it in the cycle its row is driven.
   assign w_row     = code_row(r_held);
   assign w_col     = code_col(r_held);
   assign key_col   = ((r_state == PRESS) && (key_row == w_row)) ? w_col : 3'b000;
   assign cmd_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign held_code = r_held;
   assign done      = r_done;
   assign err       = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_held  <= NO_KEY;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  if (code_valid(cmd_code)) begin
                     r_held  <= cmd_code;
                     r_cnt   <= HOLD_LOAD;
                     r_state <= PRESS;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            PRESS: begin
               if (cancel) begin
                  r_state <= IDLE;
                  r_held  <= NO_KEY;
                  r_cnt   <= '0;
               end else if (r_cnt == '0) begin
                  r_cnt   <= GAP_LOAD;
                  r_state <= GAP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            GAP: begin
               if (cancel) begin
                  r_state <= IDLE;
                  r_held  <= NO_KEY;
                  r_cnt   <= '0;
               end else if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_held  <= NO_KEY;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_held  <= NO_KEY;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: key-map table with a column scoreboard, plus timed
// sequences for hold/gap length, invalid codes, busy, cancel and async reset.
module tb_keypad_emulator;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] key_row = 4'b0000;
   logic [2:0] key_col;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_code = 4'h0;
   logic       cmd_ready;
   logic       busy;
   logic [3:0] held_code;
   logic       done;
   logic       err;
   logic       cancel = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   keypad_emulator #(.HOLD_CYCLES(16), .GAP_CYCLES(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
      .busy(busy), .held_code(held_code), .done(done), .err(err), .cancel(cancel)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] code;
      logic [3:0] row;
      logic [2:0] col;
   } vec_t;

   vec_t       vecs[16];
   logic [2:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [3:0] c);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_code  = c;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_cycles);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      check(name, k, exp_cycles);
   endtask

   function automatic logic [3:0] scan_value(input logic [3:0] row, input logic [2:0] col);
      logic [3:0] base;
      case (row)
         4'b1000: base = 4'h1;
         4'b0100: base = 4'h4;
         4'b0010: base = 4'h7;
         default: base = 4'hF;
      endcase
      if (row == 4'b0001) begin
         case (col)
            3'b100:  return 4'hC;
            3'b010:  return 4'h0;
            3'b001:  return 4'hD;
            default: return 4'hF;
         endcase
      end
      case (col)
         3'b100:  return base;
         3'b010:  return base + 4'd1;
         3'b001:  return base + 4'd2;
         default: return 4'hF;
      endcase
   endfunction

   logic [3:0] rows[4];
   logic       seen_done;

   initial begin
      vecs[0]  = '{4'h1, 4'b1000, 3'b100};
      vecs[1]  = '{4'h2, 4'b1000, 3'b010};
      vecs[2]  = '{4'h3, 4'b1000, 3'b001};
      vecs[3]  = '{4'h4, 4'b0100, 3'b100};
      vecs[4]  = '{4'h6, 4'b0100, 3'b001};
      vecs[5]  = '{4'h8, 4'b0010, 3'b010};
      vecs[6]  = '{4'h9, 4'b0010, 3'b001};
      vecs[7]  = '{4'hC, 4'b0001, 3'b100};
      vecs[8]  = '{4'h0, 4'b0001, 3'b010};
      vecs[9]  = '{4'hD, 4'b0001, 3'b001};
      vecs[10] = '{4'h8, 4'b0001, 3'b000};
      vecs[11] = '{4'h1, 4'b1100, 3'b000};
      vecs[12] = '{4'h5, 4'b0000, 3'b000};
      vecs[13] = '{4'hD, 4'b1111, 3'b000};
      vecs[14] = '{4'h7, 4'b0010, 3'b100};
      vecs[15] = '{4'h3, 4'b0100, 3'b000};
      rows[0] = 4'b1000; rows[1] = 4'b0100; rows[2] = 4'b0010; rows[3] = 4'b0001;

      // Reset held with rows cycling and a command offered
      cmd_valid = 1'b1;
      cmd_code  = 4'h5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         key_row = rows[i];
         #1;
         check("rst_col", key_col, 3'b000);
      end
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_held", held_code, 4'hF);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_held", held_code, 4'hF);

      // Code 5: same-cycle column for the whole hold, other rows dark, done at 24
      send(4'h5);
      for (int i = 0; i < 16; i++) begin
         key_row = 4'b0100;
         #1;
         check("c5_hit", key_col, 3'b010);
         key_row = rows[i % 2 == 0 ? 0 : 2];
         #1;
         check("c5_other", key_col, 3'b000);
         key_row = 4'b0001;
         #1;
         check("c5_row4", key_col, 3'b000);
         @(negedge clk);
      end
      key_row = 4'b0100;
      #1;
      check("c5_gap_col", key_col, 3'b000);
      check("c5_gap_busy", busy, 1'b1);
      wait_done("c5_gap_len", 8);
      check("c5_ready", cmd_ready, 1'b1);
      check("c5_held_f", held_code, 4'hF);
      @(negedge clk);
      check("c5_done_1cyc", done, 1'b0);

      // Key-map table; each press is cancelled once checked
      for (int i = 0; i < 16; i++) begin
         send(vecs[i].code);
         key_row = vecs[i].row;
         exp_q.push_back(vecs[i].col);
         #1;
         check($sformatf("map%0d_col", i), key_col, exp_q.pop_front());
         check($sformatf("map%0d_held", i), held_code, vecs[i].code);
         cancel = 1'b1;
         @(negedge clk);
         cancel = 1'b0;
         check($sformatf("map%0d_cancel", i), busy, 1'b0);
      end

      // Invalid codes
      foreach (rows[i]) begin
         if (i < 2) begin
            send(i == 0 ? 4'hA : 4'hE);
            key_row = 4'b1000;
            #1;
            check("inv_err", err, 1'b1);
            check("inv_busy", busy, 1'b0);
            check("inv_ready", cmd_ready, 1'b1);
            check("inv_held", held_code, 4'hF);
            check("inv_col", key_col, 3'b000);
            @(negedge clk);
            check("inv_err_1cyc", err, 1'b0);
         end
      end

      // Command while busy is dropped
      send(4'h7);
      repeat (3) @(negedge clk);
      cmd_valid = 1'b1;
      cmd_code  = 4'h3;
      @(negedge clk);
      cmd_valid = 1'b0;
      key_row   = 4'b0010;
      #1;
      check("busy_held", held_code, 4'h7);
      check("busy_err", err, 1'b0);
      check("busy_col", key_col, 3'b100);
      wait_done("busy_done", 20);

      // Cancel on PRESS cycle 5: no done afterwards
      send(4'h9);
      repeat (4) @(negedge clk);
      key_row = 4'b0010;
      #1;
      check("cx_col_c5", key_col, 3'b001);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      #1;
      check("cx_col", key_col, 3'b000);
      check("cx_busy", busy, 1'b0);
      check("cx_held", held_code, 4'hF);
      seen_done = 1'b0;
      repeat (30) begin
         @(negedge clk);
         seen_done = seen_done | done;
      end
      check("cx_no_done", seen_done, 1'b0);

      // Cancel in IDLE is inert; cancel with a command in IDLE still accepts
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cx_idle_ready", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_code  = 4'h2;
      cancel    = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cancel    = 1'b0;
      check("cx_cmd_busy", busy, 1'b1);
      check("cx_cmd_held", held_code, 4'h2);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;

      // Async reset mid-PRESS and mid-GAP, no clock edge needed
      send(4'h1);
      key_row = 4'b1000;
      #1;
      check("ar_press_col", key_col, 3'b100);
      #2 rst = 1'b0;
      #1;
      check("ar_press_col0", key_col, 3'b000);
      check("ar_press_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      send(4'h1);
      repeat (18) @(negedge clk);
      check("ar_gap_busy_pre", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("ar_gap_busy", busy, 1'b0);
      check("ar_gap_held", held_code, 4'hF);
      check("ar_gap_ready", cmd_ready, 1'b1);
      check("ar_gap_done", done, 1'b0);
      check("ar_gap_col", key_col, 3'b000);
      @(negedge clk);
      rst = 1'b1;

      // Scanner loopback for key 7
      send(4'h7);
      for (int i = 0; i < 16; i++) begin
         key_row = rows[i % 4];
         #1;
         check("lb_hold", scan_value(key_row, key_col), (i % 4 == 2) ? 4'h7 : 4'hF);
         @(negedge clk);
      end
      wait_done("lb_done", 8);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         key_row = rows[i];
         #1;
         check("lb_after", scan_value(key_row, key_col), 4'hF);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
